vector_serializer: RTL and testbench
====================================

VECTOR_SERIALIZER -- requirements
Module: vector_serializer

Interface
REQ-001 Parameter N, default 8: lanes per vector.
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 Parameter DEPTH, default 4: vector slots in the internal circular queue; a power of 2, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 valid_in  input  1  vector_in and eof_in are valid this cycle.
REQ-007 eof_in  input  1  end-of-frame flag carried with the vector.
REQ-008 vector_in  input  DATA_WIDTH x [N-1:0]  vector to enqueue (unpacked array).
REQ-009 ready_out  output  1  queue can accept a vector this cycle.
REQ-010 ready_in  input  1  downstream accepts the current lane beat.
REQ-011 valid_out  output  1  data_out holds a valid lane beat.
REQ-012 data_out  output  DATA_WIDTH  current lane value.
REQ-013 last_lane_out  output  1  current beat is lane N-1.
REQ-014 eof_out  output  1  asserted on the last-lane beat of a vector enqueued with eof_in=1; 0 on all other beats.
REQ-015 occupancy  output  $clog2(DEPTH+1)  number of vectors stored, including the vector being serialized.

Function
REQ-016 Enqueue: when valid_in && ready_out, the vector and eof are written at the head pointer; head increments modulo DEPTH.
REQ-017 ready_out SHALL equal (occupancy != DEPTH) and be derived from registered state only.
REQ-018 If valid_in is high while ready_out is low, the input is dropped and no state changes; the block never overwrites a stored slot.
REQ-019 FSM states: IDLE (queue empty) and SEND.
- IDLE -> SEND on the edge after the queue first becomes non-empty.
- SEND -> IDLE after the last-lane transfer when no other vector remains and none is enqueued on that edge.
REQ-020 In SEND, the output wiring is:
- valid_out=1
- data_out = mem[tail][lane]
- last_lane_out = (lane==N-1)
- eof_out = last_lane_out && eof[tail]
- lane is a counter 0..N-1; lane 0 is sent first.
REQ-021 Transfer occurs when valid_out && ready_in.
- If lane < N-1, the transfer increments lane.
- If lane == N-1, the transfer resets lane to 0 and pops the vector: tail increments modulo DEPTH.
REQ-022 While ready_in=0, all outputs hold stable and lane/tail do not change.
REQ-023 Latency: a vector accepted at edge t into an empty queue presents lane 0 in the cycle after edge t+1. With ready_in held high, its N beats are then contiguous.
REQ-024 Back-to-back: if another vector is queued when lane N-1 transfers, lane 0 of that vector is presented the next cycle with no bubble.
REQ-025 Simultaneous enqueue and pop on the same edge: occupancy is unchanged. This is legal, including at occupancy DEPTH-1 and when occupancy is 1.
REQ-026 At full, ready_out=0 even if a pop occurs on the same edge; the freed slot is offered in the following cycle.
REQ-027 Pointers wrap modulo DEPTH. Full and empty are distinguished only by occupancy, not by pointer equality.
REQ-028 In IDLE: valid_out=0, last_lane_out=0, eof_out=0, and data_out=0.

Reset
REQ-029 While reset_n=0, the following take these values:
- head=0, tail=0, lane=0
- occupancy=0, FSM=IDLE
- valid_out=0, last_lane_out=0, eof_out=0, data_out=0
- ready_out=0
REQ-030 In the first cycle after reset_n deasserts, ready_out=1.
REQ-031 Reset asserted mid-vector discards all stored and partially sent vectors; no beat is emitted after reset release until a new enqueue.
REQ-032 Queue data storage is not reset; eof flags are reset to 0.

Structure
REQ-033 A shared package holds the FSM state enum (IDLE, SEND) and the default N/DATA_WIDTH/DEPTH constants, and is reused by inputBuffer-adjacent blocks.
REQ-034 One sub-module, lane_counter, is natural: a modulo-N counter with enable and an N-1 terminal flag; everything else is inline.
REQ-035 The storage is a register array: DEPTH entries of N*DATA_WIDTH bits plus an eof bit per entry; no RAM macro is used.

Verification (N=4, DATA_WIDTH=32, DEPTH=4)
REQ-036 Single vector {0x10,0x11,0x12,0x13}, eof=1, ready_in=1 -> beats 0x10..0x13 on 4 consecutive cycles starting 2 cycles after accept; last_lane_out and eof_out high only on 0x13; occupancy returns to 0.
REQ-037 Enqueue 5 vectors back-to-back with ready_in=0 -> ready_out drops after the 4th accept; the 5th is dropped; occupancy=4; raising ready_in yields 16 beats in order with no bubble.
REQ-038 ready_in toggling 1,0,1,0 mid-vector -> data_out is stable during stalls and no lane is skipped or repeated.
REQ-039 At occupancy=4, pop the last lane while valid_in=1 -> the input is not accepted that cycle; it is accepted on the next cycle; occupancy goes 4->3->4.
REQ-040 Issue 9 vectors paced so the queue never fills -> the head and tail pointers wrap twice; output order and eof flags match input.
REQ-041 Assert reset_n=0 during lane 2 with 2 vectors queued -> all outputs are 0 immediately; after release, no beats and occupancy=0 until a new enqueue.

Source files
------------

// File: rtl/vector_serializer_pkg.sv
// Shared types and default sizing for the vector serializer and neighbouring
// input-buffer blocks.
package vector_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int unsigned DEF_N          = 8;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_DEPTH      = 4;

   // Index width that stays legal for a count of one.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vector_serializer_if.sv
// Enqueue and lane-beat handshake bundle for the vector serializer.
interface vector_serializer_if
   import vector_serializer_pkg::*;
#(
   parameter int unsigned N          = DEF_N,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH
);
   logic                         valid_in;
   logic                         eof_in;
   logic [DATA_WIDTH-1:0]        vector_in [N-1:0];
   logic                         ready_out;
   logic                         ready_in;
   logic                         valid_out;
   logic [DATA_WIDTH-1:0]        data_out;
   logic                         last_lane_out;
   logic                         eof_out;
   logic [$clog2(DEPTH+1)-1:0]   occupancy;

   modport master (
      output valid_in, eof_in, vector_in, ready_in,
      input  ready_out, valid_out, data_out, last_lane_out, eof_out, occupancy
   );

   modport slave (
      input  valid_in, eof_in, vector_in, ready_in,
      output ready_out, valid_out, data_out, last_lane_out, eof_out, occupancy
   );
endinterface

// File: rtl/vector_serializer_lane_counter.sv
// Modulo-N lane counter; o_last flags lane N-1 so the next enabled step wraps.
module lane_counter
   import vector_serializer_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   localparam int unsigned LW = idx_width(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_en,
   output logic [LW-1:0] o_lane,
   output logic          o_last
);
   logic [LW-1:0] r_lane;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lane <= '0;
      end else if (i_en) begin
         r_lane <= o_last ? '0 : r_lane + LW'(1);
      end
   end

   assign o_lane = r_lane;
   assign o_last = (r_lane == LW'(N - 1));
endmodule

// File: rtl/vector_serializer.sv
// Circular queue of N-lane vectors, emitted one lane per accepted beat.
module vector_serializer
   import vector_serializer_pkg::*;
#(
   parameter int unsigned N          = DEF_N,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               reset_n,
   vector_serializer_if.slave bus
);
   localparam int unsigned PW = idx_width(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH + 1);
   localparam int unsigned LW = idx_width(N);
   localparam int unsigned VW = N * DATA_WIDTH;

   state_t                r_state;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [OW-1:0]         r_occ;
   logic                  r_ready;
   logic                  r_eof [DEPTH];
   logic [VW-1:0]         r_mem [DEPTH];

   logic                  w_enq;
   logic                  w_xfer;
   logic                  w_pop;
   logic                  w_last;
   logic [LW-1:0]         w_lane;
   logic [OW-1:0]         w_occ_next;
   logic [VW-1:0]         w_vec_packed;
   logic [VW-1:0]         w_word;
   logic [DATA_WIDTH-1:0] w_data;

   assign w_enq      = bus.valid_in && r_ready;
   assign w_xfer     = (r_state == SEND) && bus.ready_in;
   assign w_pop      = w_xfer && w_last;
   assign w_occ_next = r_occ + OW'(w_enq) - OW'(w_pop);

   lane_counter #(.N(N)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_xfer),
      .o_lane  (w_lane),
      .o_last  (w_last)
   );

   always_comb begin
      w_vec_packed = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_vec_packed[i*DATA_WIDTH +: DATA_WIDTH] = bus.vector_in[i];
      end
   end

   // Payload storage carries no reset; only control and eof flags are cleared.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_head] <= w_vec_packed;
      end
   end

   // ready is registered from next occupancy, so a pop at full frees the slot one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_head  <= '0;
         r_tail  <= '0;
         r_occ   <= '0;
         r_ready <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_eof[i] <= 1'b0;
         end
      end else begin
         if (w_enq) begin
            r_head        <= r_head + PW'(1);
            r_eof[r_head] <= bus.eof_in;
         end
         if (w_pop) begin
            r_tail <= r_tail + PW'(1);
         end
         r_occ   <= w_occ_next;
         r_ready <= (w_occ_next != OW'(DEPTH));
         case (r_state)
            IDLE:    if (r_occ != '0) r_state <= SEND;
            SEND:    if (w_pop && (w_occ_next == '0)) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_word = r_mem[r_tail];

   always_comb begin
      w_data = '0;
      if (r_state == SEND) begin
         w_data = w_word[32'(w_lane) * DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.ready_out     = r_ready;
   assign bus.valid_out     = (r_state == SEND);
   assign bus.data_out      = w_data;
   assign bus.last_lane_out = (r_state == SEND) && w_last;
   assign bus.eof_out       = (r_state == SEND) && w_last && r_eof[r_tail];
   assign bus.occupancy     = r_occ;
endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer with N=4, DATA_WIDTH=32, DEPTH=4.
module tb_vector_serializer;
   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   vector_serializer_if #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_if ();

   vector_serializer #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input logic [31:0] base, input logic eof);
      for (int i = 0; i < int'(N); i++) bus_if.vector_in[i] = base + 32'(i);
      bus_if.eof_in = eof;
   endtask

   task automatic do_reset;
      reset_n         = 1'b0;
      bus_if.valid_in = 1'b0;
      bus_if.ready_in = 1'b0;
      load_vec(32'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      reset_n         = 1'b0;
      bus_if.valid_in = 1'b0;
      bus_if.ready_in = 1'b1;
      load_vec(32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus_if.valid_out); end
      n_checks++; if (bus_if.data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", bus_if.data_out); end
      n_checks++; if (bus_if.last_lane_out !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b expected 0", bus_if.last_lane_out); end
      n_checks++; if (bus_if.eof_out !== 1'b0) begin n_fail++; $display("FAIL rst_eof: got %b expected 0", bus_if.eof_out); end
      n_checks++; if (bus_if.ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus_if.ready_out); end
      n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", bus_if.occupancy); end
      @(negedge clk) reset_n = 1'b1;
      tick();
      n_checks++; if (bus_if.ready_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", bus_if.ready_out); end
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b expected 0", bus_if.valid_out); end
   endtask

   task automatic test_single;
      logic [31:0] exp;
      do_reset();
      bus_if.ready_in = 1'b1;
      load_vec(32'h10, 1'b1);
      bus_if.valid_in = 1'b1;
      tick();
      bus_if.valid_in = 1'b0;
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_gap_valid: got %b expected 0", bus_if.valid_out); end
      n_checks++; if (bus_if.occupancy !== 3'd1) begin n_fail++; $display("FAIL single_occ: got %0d expected 1", bus_if.occupancy); end
      tick();
      for (int k = 0; k < 4; k++) begin
         exp = 32'h10 + 32'(k);
         n_checks++; if (bus_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid beat %0d: got %b expected 1", k, bus_if.valid_out); end
         n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL single_data beat %0d: got %h expected %h", k, bus_if.data_out, exp); end
         n_checks++; if (bus_if.last_lane_out !== (k == 3)) begin n_fail++; $display("FAIL single_last beat %0d: got %b expected %b", k, bus_if.last_lane_out, (k == 3)); end
         n_checks++; if (bus_if.eof_out !== (k == 3)) begin n_fail++; $display("FAIL single_eof beat %0d: got %b expected %b", k, bus_if.eof_out, (k == 3)); end
         tick();
      end
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b expected 0", bus_if.valid_out); end
      n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL single_end_occ: got %0d expected 0", bus_if.occupancy); end
   endtask

   task automatic test_full_drop;
      logic [4:0]  eofv = 5'b01010;
      logic [31:0] exp;
      logic        exp_eof;
      int          v, l;
      do_reset();
      bus_if.ready_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (bus_if.ready_out !== (k < 4)) begin n_fail++; $display("FAIL full_ready k=%0d: got %b expected %b", k, bus_if.ready_out, (k < 4)); end
         load_vec(32'h20 + 32'(k) * 32'h10, eofv[k]);
         bus_if.valid_in = 1'b1;
         tick();
         n_checks++; if (bus_if.occupancy !== ((k < 4) ? 3'(k + 1) : 3'd4)) begin n_fail++; $display("FAIL full_occ k=%0d: got %0d expected %0d", k, bus_if.occupancy, (k < 4) ? k + 1 : 4); end
      end
      bus_if.valid_in = 1'b0;
      n_checks++; if (bus_if.data_out !== 32'h20) begin n_fail++; $display("FAIL full_stall_data: got %h expected 20", bus_if.data_out); end
      bus_if.ready_in = 1'b1;
      for (int j = 0; j < 16; j++) begin
         v = j / 4; l = j % 4;
         exp = 32'h20 + 32'(v) * 32'h10 + 32'(l);
         exp_eof = (l == 3) && eofv[v];
         n_checks++; if (bus_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL full_valid beat %0d: got %b expected 1", j, bus_if.valid_out); end
         n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL full_data beat %0d: got %h expected %h", j, bus_if.data_out, exp); end
         n_checks++; if (bus_if.eof_out !== exp_eof) begin n_fail++; $display("FAIL full_eof beat %0d: got %b expected %b", j, bus_if.eof_out, exp_eof); end
         tick();
      end
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL full_end_valid: got %b expected 0", bus_if.valid_out); end
      n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL full_end_occ: got %0d expected 0", bus_if.occupancy); end
   endtask

   task automatic test_stall;
      int          l = 0;
      logic        r;
      logic [31:0] exp;
      do_reset();
      bus_if.ready_in = 1'b0;
      load_vec(32'h70, 1'b0);
      bus_if.valid_in = 1'b1;
      tick();
      bus_if.valid_in = 1'b0;
      tick();
      for (int c = 0; c < 7; c++) begin
         r = (c % 2 == 0);
         bus_if.ready_in = r;
         exp = 32'h70 + 32'(l);
         n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL stall_data c=%0d: got %h expected %h", c, bus_if.data_out, exp); end
         n_checks++; if (bus_if.last_lane_out !== (l == 3)) begin n_fail++; $display("FAIL stall_last c=%0d: got %b expected %b", c, bus_if.last_lane_out, (l == 3)); end
         tick();
         if (r) l++;
      end
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid: got %b expected 0", bus_if.valid_out); end
   endtask

   task automatic test_full_pop;
      logic [31:0] bases [4] = '{32'h90, 32'hA0, 32'hB0, 32'hC0};
      logic [31:0] exp;
      int          v, l;
      do_reset();
      bus_if.ready_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         load_vec(32'h80 + 32'(k) * 32'h10, 1'b0);
         bus_if.valid_in = 1'b1;
         tick();
      end
      bus_if.valid_in = 1'b0;
      bus_if.ready_in = 1'b1;
      repeat (3) tick();
      n_checks++; if (bus_if.occupancy !== 3'd4) begin n_fail++; $display("FAIL pop_occ_full: got %0d expected 4", bus_if.occupancy); end
      n_checks++; if (bus_if.ready_out !== 1'b0) begin n_fail++; $display("FAIL pop_ready_full: got %b expected 0", bus_if.ready_out); end
      n_checks++; if (bus_if.data_out !== 32'h83) begin n_fail++; $display("FAIL pop_lane3: got %h expected 83", bus_if.data_out); end
      load_vec(32'hC0, 1'b1);
      bus_if.valid_in = 1'b1;
      tick();
      n_checks++; if (bus_if.occupancy !== 3'd3) begin n_fail++; $display("FAIL pop_occ_after: got %0d expected 3", bus_if.occupancy); end
      n_checks++; if (bus_if.ready_out !== 1'b1) begin n_fail++; $display("FAIL pop_ready_after: got %b expected 1", bus_if.ready_out); end
      tick();
      bus_if.valid_in = 1'b0;
      n_checks++; if (bus_if.occupancy !== 3'd4) begin n_fail++; $display("FAIL pop_occ_refill: got %0d expected 4", bus_if.occupancy); end
      for (int j = 0; j < 15; j++) begin
         v = (j + 1) / 4; l = (j + 1) % 4;
         exp = bases[v] + 32'(l);
         n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL pop_data beat %0d: got %h expected %h", j, bus_if.data_out, exp); end
         n_checks++; if (bus_if.eof_out !== ((l == 3) && (v == 3))) begin n_fail++; $display("FAIL pop_eof beat %0d: got %b expected %b", j, bus_if.eof_out, (l == 3) && (v == 3)); end
         tick();
      end
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL pop_end_valid: got %b expected 0", bus_if.valid_out); end
   endtask

   task automatic test_wrap;
      int          k = 0, o = 0, cyc = 0, v, l;
      logic [31:0] exp;
      logic        exp_eof;
      do_reset();
      bus_if.ready_in = 1'b1;
      while (o < 36 && cyc < 200) begin
         if (bus_if.valid_out === 1'b1) begin
            v = o / 4; l = o % 4;
            exp = 32'h100 * 32'(v + 1) + 32'(l);
            exp_eof = (l == 3) && (v % 3 == 0);
            n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL wrap_data beat %0d: got %h expected %h", o, bus_if.data_out, exp); end
            n_checks++; if (bus_if.eof_out !== exp_eof) begin n_fail++; $display("FAIL wrap_eof beat %0d: got %b expected %b", o, bus_if.eof_out, exp_eof); end
            o++;
         end
         if (k < 9 && cyc % 4 == 0) begin
            n_checks++; if (bus_if.ready_out !== 1'b1) begin n_fail++; $display("FAIL wrap_ready vec %0d: got %b expected 1", k, bus_if.ready_out); end
            load_vec(32'h100 * 32'(k + 1), (k % 3 == 0));
            bus_if.valid_in = 1'b1;
            k++;
         end else begin
            bus_if.valid_in = 1'b0;
         end
         tick();
         cyc++;
      end
      bus_if.valid_in = 1'b0;
      n_checks++; if (o !== 36) begin n_fail++; $display("FAIL wrap_timeout: got %0d beats expected 36", o); end
      n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL wrap_end_occ: got %0d expected 0", bus_if.occupancy); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] exp;
      do_reset();
      bus_if.ready_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         load_vec(32'h40 + 32'(k) * 32'h10, 1'b1);
         bus_if.valid_in = 1'b1;
         tick();
      end
      bus_if.valid_in = 1'b0;
      bus_if.ready_in = 1'b1;
      repeat (2) tick();
      n_checks++; if (bus_if.data_out !== 32'h42) begin n_fail++; $display("FAIL mid_lane2: got %h expected 42", bus_if.data_out); end
      reset_n = 1'b0;
      #2;
      n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus_if.valid_out); end
      n_checks++; if (bus_if.data_out !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", bus_if.data_out); end
      n_checks++; if (bus_if.last_lane_out !== 1'b0 || bus_if.eof_out !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got %b%b expected 00", bus_if.last_lane_out, bus_if.eof_out); end
      n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_occ: got %0d expected 0", bus_if.occupancy); end
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_idle_valid c=%0d: got %b expected 0", c, bus_if.valid_out); end
         n_checks++; if (bus_if.occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_idle_occ c=%0d: got %0d expected 0", c, bus_if.occupancy); end
      end
      load_vec(32'h200, 1'b0);
      bus_if.valid_in = 1'b1;
      tick();
      bus_if.valid_in = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         exp = 32'h200 + 32'(k);
         n_checks++; if (bus_if.data_out !== exp) begin n_fail++; $display("FAIL mid_new_data beat %0d: got %h expected %h", k, bus_if.data_out, exp); end
         n_checks++; if (bus_if.eof_out !== 1'b0) begin n_fail++; $display("FAIL mid_new_eof beat %0d: got %b expected 0", k, bus_if.eof_out); end
         tick();
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      bus_if.valid_in = 1'b0;
      bus_if.ready_in = 1'b0;
      bus_if.eof_in   = 1'b0;
      test_reset();
      test_single();
      test_full_drop();
      test_stall();
      test_full_pop();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
